serial_subtractor_8bits: RTL and testbench

Bit-serial two's-complement subtractor that computes `minuend - subtrahend` one bit per clock, LSB first, using a single `full_adder` cell with an inverted B operand and a fed-back carry. It is the arithmetic inverse of the parallel 8-bit adder. It trades WIDTH cycles of latency for one adder cell, and sits beside the adder as the subtract path of the datapath with a start/done handshake toward the controlling logic.

---
 rtl/arith_pkg.sv | 17 +
 rtl/full_adder.sv | 13 +
 rtl/serial_subtractor_8bits.sv | 145 ++++++++++++++
 tb/tb_serial_subtractor_8bits.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic package: default datapath width, serial-subtractor state
// encoding and the bit-counter width helper.
package arith_pkg;

  localparam int unsigned ARITH_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sub_state_t;

  // Counter spans 0..width-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by the parallel adder and serial subtractor.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic C_in,
  output logic Sum,
  output logic C_out
);

  assign Sum   = A ^ B ^ C_in;
  assign C_out = (A & B) | (A & C_in) | (B & C_in);

endmodule

// File: rtl/serial_subtractor_8bits.sv
// Bit-serial two's-complement subtractor: minuend - subtrahend, LSB first,
// one full_adder cell with inverted B and fed-back carry.
// Optional SUB_OVERFLOW_EN adds a registered signed-overflow output.
module serial_subtractor_8bits
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = ARITH_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam int unsigned RES_W = WIDTH - 1;

  sub_state_t       state;
  sub_state_t       state_next;
  logic             accept;
  logic             finish;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [RES_W-1:0] res_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             fa_sum;
  logic             fa_cout;

`ifdef SUB_OVERFLOW_EN
  logic             a_msb;
  logic             b_msb;
`endif

  // The one adder cell; B arrives already inverted from the shift register.
  full_adder u_fa (
    .A     (a_sr[0]),
    .B     (b_sr[0]),
    .C_in  (carry),
    .Sum   (fa_sum),
    .C_out (fa_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; start is only honoured from IDLE.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(WIDTH - 1)) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == RUN);

  // Operand capture and per-bit shift datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= minuend;
      b_sr   <= ~subtrahend;
      res_sr <= '0;
      carry  <= 1'b1;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= RES_W'({fa_sum, res_sr} >> 1);
      carry  <= fa_cout;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Result registers only move on the completion edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      difference <= '0;
      borrow_out <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        difference <= {fa_sum, res_sr};
        borrow_out <= ~fa_cout;
      end
    end
  end

`ifdef SUB_OVERFLOW_EN
  // Original operand MSBs, kept because the shift registers lose them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb    <= 1'b0;
      b_msb    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        a_msb <= minuend[WIDTH-1];
        b_msb <= subtrahend[WIDTH-1];
      end
      if (finish) begin
        overflow <= (a_msb != b_msb) && (fa_sum != a_msb);
      end
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor_8bits.sv
// Self-checking bench for serial_subtractor_8bits: arithmetic reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_serial_subtractor_8bits;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] minuend;
  logic [W-1:0] subtrahend;
  logic [W-1:0] difference;
  logic         borrow_out;
  logic         busy;
  logic         done;
`ifdef SUB_OVERFLOW_EN
  logic         overflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  serial_subtractor_8bits #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .minuend    (minuend),
    .subtrahend (subtrahend),
    .difference (difference),
    .borrow_out (borrow_out),
    .busy       (busy),
    .done       (done)
`ifdef SUB_OVERFLOW_EN
    ,
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic plus a latency countdown.
  logic         m_busy, m_done, m_borrow, m_ovf;
  logic [W-1:0] m_diff;
  logic         p_borrow, p_ovf;
  logic [W-1:0] p_diff;
  int           m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_borrow <= 1'b0; m_ovf <= 1'b0;
      m_diff <= '0;   m_left <= 0;
      p_diff <= '0;   p_borrow <= 1'b0; p_ovf <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          int sa, sb, sd;
          sa = int'($signed(minuend));
          sb = int'($signed(subtrahend));
          sd = sa - sb;
          m_busy   <= 1'b1;
          m_left   <= W;
          p_diff   <= W'(int'(minuend) - int'(subtrahend));
          p_borrow <= (int'(minuend) < int'(subtrahend));
          p_ovf    <= (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));
        end
      end else if (m_left == 1) begin
        m_busy   <= 1'b0;
        m_done   <= 1'b1;
        m_diff   <= p_diff;
        m_borrow <= p_borrow;
        m_ovf    <= p_ovf;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Advance to the next falling edge and compare DUT against the model.
  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("difference", 32'(difference), 32'(m_diff));
      chk("borrow_out", 32'(borrow_out), 32'(m_borrow));
`ifdef SUB_OVERFLOW_EN
      chk("overflow", 32'(overflow), 32'(m_ovf));
`endif
      if (done) n_done++;
    end
  endtask

  // One pulsed request; waits (bounded) for done and checks literal results.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_d, input logic exp_b, input logic exp_o);
    int  busy_cycles;
    bit  got;
    busy_cycles = 0;
    got = 1'b0;
    minuend = a; subtrahend = b; start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) start = 1'b0;
      if (done) begin got = 1'b1; break; end
      if (busy) busy_cycles++;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("lit_difference", 32'(difference), 32'(exp_d));
    chk("lit_borrow", 32'(borrow_out), 32'(exp_b));
    chk("busy_cycles", 32'(busy_cycles), 32'(W));
`ifdef SUB_OVERFLOW_EN
    chk("lit_overflow", 32'(overflow), 32'(exp_o));
`else
    if (exp_o) begin end
`endif
  endtask

  initial begin
    int d0;
    bit got;
    rst_n = 1'b0; start = 1'b0; minuend = '0; subtrahend = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_difference", 32'(difference), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic, borrow, wrap and equal-operand cases.
    do_op(8'h50, 8'h20, 8'h30, 1'b0, 1'b0);
    do_op(8'h20, 8'h50, 8'hD0, 1'b1, 1'b0);
    do_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    do_op(8'h7F, 8'h7F, 8'h00, 1'b0, 1'b0);
    // Signed-overflow boundaries.
    do_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    do_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
    do_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0);
    tick();

    // Start during RUN is ignored: exactly one done, result 0x06.
    d0 = n_done;
    minuend = 8'h09; subtrahend = 8'h03; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    minuend = 8'hFF; subtrahend = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    chk("ignored_done_count", 32'(n_done - d0), 32'd1);
    chk("ignored_difference", 32'(difference), 32'h06);

    // Reset mid-RUN clears everything at once; no done afterwards.
    minuend = 8'h44; subtrahend = 8'h11; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_difference", 32'(difference), 32'd0);
    chk("abort_borrow", 32'(borrow_out), 32'd0);
`ifdef SUB_OVERFLOW_EN
    chk("abort_overflow", 32'(overflow), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    d0 = n_done;
    for (int i = 0; i < 12; i++) tick();
    chk("no_done_after_abort", 32'(n_done - d0), 32'd0);
    do_op(8'h44, 8'h11, 8'h33, 1'b0, 1'b0);
    tick();

    // Start held high: back-to-back operations with the done cycle as only gap.
    minuend = 8'h05; subtrahend = 8'h02; start = 1'b1;
    tick();
    minuend = 8'h02; subtrahend = 8'h05;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) begin got = 1'b1; break; end
    end
    chk("b2b_first_done", 32'(got), 32'd1);
    chk("b2b_first_diff", 32'(difference), 32'h03);
    chk("b2b_first_borrow", 32'(borrow_out), 32'd0);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 0) chk("b2b_restart_busy", 32'(busy), 32'd1);
      if (done) begin got = 1'b1; break; end
      if (!busy) chk("b2b_busy_held", 32'(busy), 32'd1);
    end
    start = 1'b0;
    chk("b2b_second_done", 32'(got), 32'd1);
    chk("b2b_second_diff", 32'(difference), 32'hFD);
    chk("b2b_second_borrow", 32'(borrow_out), 32'd1);
    for (int i = 0; i < 12; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
